mem_bridge: RTL and testbench
=============================

MEM_BRIDGE -- requirements
Module: mem_bridge

Interface
REQ-001 SHALL have parameter MEM_AW, default 14: word-address width of the backing RAM.
REQ-002 SHALL have parameter RD_LAT, default 1: RAM read latency in cycles, legal range 1..4.
REQ-003 SHALL have port clk, input, 1: single clock; all logic on posedge.
REQ-004 SHALL have port rst, input, 1: reset, synchronous, active-high.
REQ-005 SHALL have port PC, input, 32: instruction fetch byte address.
REQ-006 SHALL have port Inst_Req_Valid, input, 1: fetch request pending.
REQ-007 SHALL have port Inst_Req_Ack, output, 1: one-cycle fetch-accept pulse.
REQ-008 SHALL have port Instruction, output, 32: fetched word.
REQ-009 SHALL have ports Inst_Valid (output, 1, fetch data valid) and Inst_Ack (input, 1, CPU accepts fetch data).
REQ-010 SHALL have ports Address (input, 32), MemRead (input, 1), MemWrite (input, 1), Write_data (input, 32), Write_strb (input, 4): CPU data request.
REQ-011 SHALL have port Mem_Req_Ack, output, 1: one-cycle data-request-accept pulse.
REQ-012 SHALL have ports Read_data (output, 32), Read_data_Valid (output, 1), Read_data_Ack (input, 1): load response.
REQ-013 SHALL have ports ram_en (output, 1), ram_addr (output, MEM_AW), ram_wstrb (output, 4), ram_wdata (output, 32), ram_rdata (input, 32): single-port RAM.
REQ-014 SHALL have ports inst_cnt and data_cnt, output, 32 each: accepted fetch / data request counts.

Function
REQ-015 SHALL implement FSM states IDLE, I_RD, I_RSP, D_WR, D_RD, D_RSP, one-hot encoded.
REQ-016 In IDLE, SHALL arbitrate with fixed priority: MemWrite > MemRead > Inst_Req_Valid; MemRead and MemWrite both high SHALL be served as a write only.
REQ-017 On acceptance, SHALL pulse the matching ack (Inst_Req_Ack or Mem_Req_Ack) high for exactly one cycle and latch address, strobe and data.
REQ-018 Write path: IDLE -> D_WR; in D_WR SHALL drive ram_en=1, ram_wstrb=latched Write_strb, ram_addr=latched Address[MEM_AW+1:2] for one cycle, then -> IDLE.
REQ-019 Read paths: IDLE -> I_RD or D_RD; SHALL drive ram_en=1, ram_wstrb=0 on the first cycle, wait RD_LAT cycles using a down-counter, capture ram_rdata, then -> I_RSP or D_RSP.
REQ-020 In I_RSP, SHALL hold Inst_Valid=1 and Instruction stable until the cycle Inst_Valid&&Inst_Ack, then -> IDLE with Inst_Valid=0 next cycle.
REQ-021 In D_RSP, SHALL hold Read_data_Valid=1 and Read_data stable until Read_data_Valid&&Read_data_Ack, then -> IDLE.
REQ-022 Address bits [1:0] SHALL be ignored; byte selection is the CPU's job; address bits above MEM_AW+1 SHALL be ignored (wrap-around).
REQ-023 ram_en SHALL be 0 and ram_wstrb SHALL be 0 in every cycle not stated above.
REQ-024 Minimum latencies: write accept-to-RAM-write 1 cycle; read accept-to-Valid RD_LAT+1 cycles; back-to-back requests SHALL see one IDLE cycle between transactions.
REQ-025 Requests arriving while not in IDLE SHALL remain un-acked until IDLE; no request SHALL be dropped or acked twice.
REQ-026 inst_cnt and data_cnt SHALL increment by 1 on each Inst_Req_Ack / Mem_Req_Ack pulse and wrap from 0xFFFFFFFF to 0.

Reset
REQ-027 On rst, SHALL enter IDLE and clear Inst_Req_Ack, Mem_Req_Ack, Inst_Valid, Read_data_Valid, ram_en, ram_wstrb, inst_cnt, data_cnt to 0; Instruction and Read_data to 0.
REQ-028 rst asserted mid-transaction SHALL abort it with no further RAM access and no response; a pending write not yet in D_WR SHALL not reach RAM.

Structure
REQ-029 State encodings and the RD_LAT limit SHALL live in shared package mem_bridge_pkg.
REQ-030 The RAM SHALL be a separate sub-module, bram_sp (byte-strobed, RD_LAT registered read), instantiated only in the testbench and SoC top, not inside mem_bridge.

Verification
REQ-031 Fetch: PC=0x10, RAM[4]=0x24020005, Inst_Ack high -> Inst_Req_Ack pulse, Inst_Valid at cycle RD_LAT+1, Instruction=0x24020005, inst_cnt=1.
REQ-032 Byte write: Address=0x103, Write_strb=4'b1000, Write_data=0xAB000000 -> RAM[0x40]=0xAB<<24 with lower three bytes unchanged.
REQ-033 Collision: MemRead and Inst_Req_Valid asserted same cycle -> data read served first, fetch acked after data response handshake.
REQ-034 Backpressure: Read_data_Ack held 0 for 5 cycles -> Read_data_Valid and Read_data stable all 5 cycles; no RAM access in those cycles.
REQ-035 Reset mid-read: rst in D_RD -> next cycle IDLE, Read_data_Valid never asserts, data_cnt=0.
REQ-036 RD_LAT=3 regression: repeat REQ-031 -> Inst_Valid at cycle 4 after accept.

Source files
------------

// File: rtl/mem_bridge_pkg.sv
// mem_bridge_pkg: one-hot FSM encoding, read-latency limits and latency-counter helper shared by mem_bridge
package mem_bridge_pkg;
  localparam int RD_LAT_MIN = 1;
  localparam int RD_LAT_MAX = 4;
  localparam int CNT_W = $clog2(RD_LAT_MAX + 1);
  typedef enum logic [5:0] {
    IDLE  = 6'b000001,
    I_RD  = 6'b000010,
    I_RSP = 6'b000100,
    D_WR  = 6'b001000,
    D_RD  = 6'b010000,
    D_RSP = 6'b100000
  } state_t;
  function automatic logic [CNT_W-1:0] lat_cnt(input int lat);
    return CNT_W'(lat < RD_LAT_MIN ? RD_LAT_MIN : lat > RD_LAT_MAX ? RD_LAT_MAX : lat);
  endfunction
endpackage

// File: rtl/bram_sp.sv
// bram_sp: single-port byte-strobed RAM, reads (en=1, wstrb=0) return data after RD_LAT clock edges on rdata
module bram_sp #(
  parameter int AW = 14,
  parameter int RD_LAT = 1
) (
  input  logic          clk,
  input  logic          en,
  input  logic [AW-1:0] addr,
  input  logic [3:0]    wstrb,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata
);
  logic [31:0] r_mem [2**AW];
  logic [31:0] r_pipe [RD_LAT];
  always_ff @(posedge clk) begin
    if (en)
      for (int b = 0; b < 4; b++)
        if (wstrb[b]) r_mem[addr][8*b +: 8] <= wdata[8*b +: 8];
    if (en && wstrb == 4'h0) r_pipe[0] <= r_mem[addr];
    for (int s = 1; s < RD_LAT; s++) r_pipe[s] <= r_pipe[s-1];
  end
  assign rdata = r_pipe[RD_LAT-1];
endmodule

// File: rtl/mem_bridge.sv
// mem_bridge: arbitrates CPU store > load > fetch onto one single-port RAM (CPU fetch/data ports in, RAM port out, accept counters)
module mem_bridge
  import mem_bridge_pkg::*;
#(
  parameter int MEM_AW = 14,
  parameter int RD_LAT = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [31:0]       PC,
  input  logic              Inst_Req_Valid,
  output logic              Inst_Req_Ack,
  output logic [31:0]       Instruction,
  output logic              Inst_Valid,
  input  logic              Inst_Ack,
  input  logic [31:0]       Address,
  input  logic              MemRead,
  input  logic              MemWrite,
  input  logic [31:0]       Write_data,
  input  logic [3:0]        Write_strb,
  output logic              Mem_Req_Ack,
  output logic [31:0]       Read_data,
  output logic              Read_data_Valid,
  input  logic              Read_data_Ack,
  output logic              ram_en,
  output logic [MEM_AW-1:0] ram_addr,
  output logic [3:0]        ram_wstrb,
  output logic [31:0]       ram_wdata,
  input  logic [31:0]       ram_rdata,
  output logic [31:0]       inst_cnt,
  output logic [31:0]       data_cnt
);
  localparam logic [CNT_W-1:0] LAT = lat_cnt(RD_LAT);
  state_t r_state, w_next;
  logic [CNT_W-1:0] r_cnt;
  logic [MEM_AW-1:0] r_addr;
  logic [3:0] r_strb;
  logic [31:0] r_wdata, r_inst, r_rdata, r_icnt, r_dcnt;
  logic r_iack, r_dack;
  logic w_wr, w_rd, w_if, w_done, w_reading, w_unused;
  assign w_wr = r_state == IDLE && MemWrite;
  assign w_rd = r_state == IDLE && !MemWrite && MemRead;
  assign w_if = r_state == IDLE && !MemWrite && !MemRead && Inst_Req_Valid;
  assign w_done = r_cnt == '0;
  assign w_reading = r_state == I_RD || r_state == D_RD;
  assign w_unused = ^{Address[1:0], Address[31:MEM_AW+2], PC[1:0], PC[31:MEM_AW+2]};
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    w_next = w_wr ? D_WR : w_rd ? D_RD : w_if ? I_RD : IDLE;
      I_RD:    w_next = w_done ? I_RSP : I_RD;
      D_RD:    w_next = w_done ? D_RSP : D_RD;
      D_WR:    w_next = IDLE;
      I_RSP:   w_next = Inst_Ack ? IDLE : I_RSP;
      D_RSP:   w_next = Read_data_Ack ? IDLE : D_RSP;
      default: w_next = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_iack  <= 1'b0;
      r_dack  <= 1'b0;
      r_icnt  <= '0;
      r_dcnt  <= '0;
      r_inst  <= '0;
      r_rdata <= '0;
      r_cnt   <= '0;
      r_addr  <= '0;
      r_strb  <= '0;
      r_wdata <= '0;
    end else begin
      r_state <= w_next;
      r_iack  <= w_if;
      r_dack  <= w_wr || w_rd;
      if (w_if) r_icnt <= r_icnt + 32'd1;
      if (w_wr || w_rd) r_dcnt <= r_dcnt + 32'd1;
      if (w_wr || w_rd || w_if) begin
        r_addr  <= w_if ? PC[MEM_AW+1:2] : Address[MEM_AW+1:2];
        r_strb  <= Write_strb;
        r_wdata <= Write_data;
        r_cnt   <= LAT;
      end else if (w_reading && !w_done) r_cnt <= r_cnt - 1'b1;
      if (r_state == I_RD && w_done) r_inst <= ram_rdata;
      if (r_state == D_RD && w_done) r_rdata <= ram_rdata;
    end
  end
  assign Inst_Req_Ack    = r_iack;
  assign Mem_Req_Ack     = r_dack;
  assign Instruction     = r_inst;
  assign Read_data       = r_rdata;
  assign Inst_Valid      = r_state == I_RSP;
  assign Read_data_Valid = r_state == D_RSP;
  assign ram_en          = r_state == D_WR || (w_reading && r_cnt == LAT);
  assign ram_wstrb       = r_state == D_WR ? r_strb : 4'h0;
  assign ram_addr        = r_addr;
  assign ram_wdata       = r_wdata;
  assign inst_cnt        = r_icnt;
  assign data_cnt        = r_dcnt;
endmodule

// File: tb/tb_mem_bridge.sv
// tb_mem_bridge: directed checks of mem_bridge with RD_LAT=1 and RD_LAT=3 instances, each backed by a bram_sp
module tb_mem_bridge;
  localparam int AW = 14;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  logic [31:0] PC = '0, Address = '0, Write_data = '0;
  logic [3:0] Write_strb = '0;
  logic Inst_Req_Valid = 1'b0, Inst_Ack = 1'b1, MemRead = 1'b0, MemWrite = 1'b0, Read_data_Ack = 1'b1;
  logic Inst_Req_Ack, Inst_Valid, Mem_Req_Ack, Read_data_Valid, ram_en;
  logic [31:0] Instruction, Read_data, ram_wdata, ram_rdata, inst_cnt, data_cnt;
  logic [AW-1:0] ram_addr;
  logic [3:0] ram_wstrb;
  logic [31:0] pc_3 = '0, addr_3 = '0, wd_3 = '0;
  logic iv_3 = 1'b0, mw_3 = 1'b0;
  logic iack_3, ivld_3, mack_3, rdv_3, en_3;
  logic [31:0] ins_3, rd_3, wdat_3, rdat_3, icnt_3, dcnt_3;
  logic [AW-1:0] ra_3;
  logic [3:0] ws_3;
  int n_chk = 0, n_err = 0;

  mem_bridge #(.MEM_AW(AW), .RD_LAT(1)) u_dut (
    .clk(clk), .rst(rst), .PC(PC), .Inst_Req_Valid(Inst_Req_Valid), .Inst_Req_Ack(Inst_Req_Ack),
    .Instruction(Instruction), .Inst_Valid(Inst_Valid), .Inst_Ack(Inst_Ack), .Address(Address),
    .MemRead(MemRead), .MemWrite(MemWrite), .Write_data(Write_data), .Write_strb(Write_strb),
    .Mem_Req_Ack(Mem_Req_Ack), .Read_data(Read_data), .Read_data_Valid(Read_data_Valid),
    .Read_data_Ack(Read_data_Ack), .ram_en(ram_en), .ram_addr(ram_addr), .ram_wstrb(ram_wstrb),
    .ram_wdata(ram_wdata), .ram_rdata(ram_rdata), .inst_cnt(inst_cnt), .data_cnt(data_cnt)
  );
  bram_sp #(.AW(AW), .RD_LAT(1)) u_ram (
    .clk(clk), .en(ram_en), .addr(ram_addr), .wstrb(ram_wstrb), .wdata(ram_wdata), .rdata(ram_rdata)
  );
  mem_bridge #(.MEM_AW(AW), .RD_LAT(3)) u_dut3 (
    .clk(clk), .rst(rst), .PC(pc_3), .Inst_Req_Valid(iv_3), .Inst_Req_Ack(iack_3),
    .Instruction(ins_3), .Inst_Valid(ivld_3), .Inst_Ack(1'b1), .Address(addr_3),
    .MemRead(1'b0), .MemWrite(mw_3), .Write_data(wd_3), .Write_strb(4'hF),
    .Mem_Req_Ack(mack_3), .Read_data(rd_3), .Read_data_Valid(rdv_3),
    .Read_data_Ack(1'b1), .ram_en(en_3), .ram_addr(ra_3), .ram_wstrb(ws_3),
    .ram_wdata(wdat_3), .ram_rdata(rdat_3), .inst_cnt(icnt_3), .data_cnt(dcnt_3)
  );
  bram_sp #(.AW(AW), .RD_LAT(3)) u_ram3 (
    .clk(clk), .en(en_3), .addr(ra_3), .wstrb(ws_3), .wdata(wdat_3), .rdata(rdat_3)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  task automatic do_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    bit seen;
    seen = 1'b0;
    @(negedge clk);
    Address = a; Write_data = d; Write_strb = s; MemWrite = 1'b1;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      if (Mem_Req_Ack) begin
        seen = 1'b1;
        MemWrite = 1'b0;
        chk("wr_ram_en", 32'(ram_en), 32'd1);
        chk("wr_ram_wstrb", 32'(ram_wstrb), 32'(s));
      end
    end
    if (!seen) begin
      MemWrite = 1'b0;
      chk("wr_ack_timeout", 32'd0, 32'd1);
    end
  endtask

  task automatic do_read(input logic [31:0] a, output logic [31:0] d, output int lat);
    bit seen;
    seen = 1'b0; d = '0; lat = 0;
    @(negedge clk);
    Address = a; MemRead = 1'b1;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      if (Mem_Req_Ack) begin
        seen = 1'b1;
        MemRead = 1'b0;
      end
    end
    if (!seen) begin
      MemRead = 1'b0;
      chk("rd_ack_timeout", 32'd0, 32'd1);
      return;
    end
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      lat++;
      if (Read_data_Valid) begin
        seen = 1'b1;
        d = Read_data;
      end
    end
    if (!seen) chk("rd_valid_timeout", 32'd0, 32'd1);
  endtask

  task automatic do_fetch(input logic [31:0] pc, output logic [31:0] ins, output int lat);
    bit seen;
    seen = 1'b0; ins = '0; lat = 0;
    @(negedge clk);
    PC = pc; Inst_Req_Valid = 1'b1;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      if (Inst_Req_Ack) begin
        seen = 1'b1;
        Inst_Req_Valid = 1'b0;
        chk("if_ram_en", 32'(ram_en), 32'd1);
        chk("if_ram_wstrb", 32'(ram_wstrb), 32'd0);
        chk("if_ram_addr", 32'(ram_addr), 32'(pc[AW+1:2]));
      end
    end
    if (!seen) begin
      Inst_Req_Valid = 1'b0;
      chk("if_ack_timeout", 32'd0, 32'd1);
      return;
    end
    @(negedge clk);
    lat = 1;
    chk("if_ack_pulse", 32'(Inst_Req_Ack), 32'd0);
    while (!Inst_Valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    ins = Instruction;
    @(negedge clk);
    chk("if_valid_drop", 32'(Inst_Valid), 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [31:0] rd;
    int lat, n, c_mack, c_rsp, c_iack, c_ival, n_iack;
    bit seen;
    repeat (3) @(negedge clk);
    chk("rst_inst_req_ack", 32'(Inst_Req_Ack), 32'd0);
    chk("rst_mem_req_ack", 32'(Mem_Req_Ack), 32'd0);
    chk("rst_inst_valid", 32'(Inst_Valid), 32'd0);
    chk("rst_rd_valid", 32'(Read_data_Valid), 32'd0);
    chk("rst_ram_en", 32'(ram_en), 32'd0);
    chk("rst_ram_wstrb", 32'(ram_wstrb), 32'd0);
    chk("rst_inst_cnt", inst_cnt, 32'd0);
    chk("rst_data_cnt", data_cnt, 32'd0);
    chk("rst_instruction", Instruction, 32'd0);
    chk("rst_read_data", Read_data, 32'd0);
    chk("rst3_inst_cnt", icnt_3, 32'd0);
    rst = 1'b0;

    do_write(32'h10, 32'h24020005, 4'hF);
    do_write(32'h100, 32'h11223344, 4'hF);
    do_write(32'h300, 32'h00000000, 4'hF);
    do_fetch(32'h10, rd, lat);
    chk("fetch_data", rd, 32'h24020005);
    chk("fetch_latency", 32'(lat), 32'd2);
    chk("fetch_inst_cnt", inst_cnt, 32'd1);

    do_write(32'h103, 32'hAB000000, 4'b1000);
    do_read(32'h100, rd, lat);
    chk("byte_write", rd, 32'hAB223344);
    chk("read_latency", 32'(lat), 32'd2);
    do_read(32'h10 | 32'h0001_0000, rd, lat);
    chk("addr_wrap", rd, 32'h24020005);
    do_read(32'h13, rd, lat);
    chk("low_bits_ignored", rd, 32'h24020005);
    chk("data_cnt_7", data_cnt, 32'd7);

    @(negedge clk);
    Address = 32'h200; Write_data = 32'h5A5A5A5A; Write_strb = 4'hF; MemWrite = 1'b1; MemRead = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      if (Mem_Req_Ack) begin
        seen = 1'b1;
        MemWrite = 1'b0; MemRead = 1'b0;
        chk("prio_wstrb", 32'(ram_wstrb), 32'hF);
      end
    end
    if (!seen) begin
      MemWrite = 1'b0; MemRead = 1'b0;
      chk("prio_ack_timeout", 32'd0, 32'd1);
    end
    n = 0;
    repeat (6) begin
      @(negedge clk);
      n += int'(Read_data_Valid);
    end
    chk("prio_no_read_rsp", 32'(n), 32'd0);
    do_read(32'h200, rd, lat);
    chk("prio_write_data", rd, 32'h5A5A5A5A);

    @(negedge clk);
    Address = 32'h100; MemRead = 1'b1; PC = 32'h10; Inst_Req_Valid = 1'b1;
    c_mack = 0; c_rsp = 0; c_iack = 0; c_ival = 0; n_iack = 0;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      if (Mem_Req_Ack) begin
        c_mack = c;
        MemRead = 1'b0;
      end
      if (Inst_Req_Ack) begin
        n_iack++;
        if (c_iack == 0) c_iack = c;
        Inst_Req_Valid = 1'b0;
      end
      if (Read_data_Valid && c_rsp == 0) begin
        c_rsp = c;
        chk("col_read_data", Read_data, 32'hAB223344);
      end
      if (Inst_Valid && c_ival == 0) begin
        c_ival = c;
        chk("col_instruction", Instruction, 32'h24020005);
      end
    end
    chk("col_mem_ack_cycle", 32'(c_mack), 32'd1);
    chk("col_rsp_cycle", 32'(c_rsp), 32'd3);
    chk("col_inst_ack_cycle", 32'(c_iack), 32'd5);
    chk("col_inst_valid_cycle", 32'(c_ival), 32'd7);
    chk("col_inst_ack_once", 32'(n_iack), 32'd1);
    chk("col_inst_cnt", inst_cnt, 32'd2);
    chk("col_data_cnt", data_cnt, 32'd10);

    Read_data_Ack = 1'b0;
    do_read(32'h100, rd, lat);
    chk("bp_data", rd, 32'hAB223344);
    n = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_valid_held", 32'(Read_data_Valid), 32'd1);
      chk("bp_data_stable", Read_data, 32'hAB223344);
      n += int'(ram_en);
    end
    chk("bp_no_ram_access", 32'(n), 32'd0);
    Read_data_Ack = 1'b1;
    @(negedge clk);
    chk("bp_release", 32'(Read_data_Valid), 32'd0);

    @(negedge clk);
    Address = 32'h100; MemRead = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      if (Mem_Req_Ack) begin
        seen = 1'b1;
        chk("rst_rd_in_d_rd", 32'(ram_en), 32'd1);
        MemRead = 1'b0;
        rst = 1'b1;
      end
    end
    if (!seen) begin
      MemRead = 1'b0;
      chk("rst_rd_ack_timeout", 32'd0, 32'd1);
    end
    @(negedge clk);
    chk("rst_rd_valid", 32'(Read_data_Valid), 32'd0);
    chk("rst_rd_ram_en", 32'(ram_en), 32'd0);
    chk("rst_rd_data_cnt", data_cnt, 32'd0);
    rst = 1'b0;
    n = 0;
    repeat (8) begin
      @(negedge clk);
      n += int'(Read_data_Valid) + int'(ram_en);
    end
    chk("rst_rd_quiet", 32'(n), 32'd0);

    @(negedge clk);
    Address = 32'h300; Write_data = 32'hDEADBEEF; Write_strb = 4'hF; MemWrite = 1'b1; rst = 1'b1;
    @(negedge clk);
    chk("rst_wr_no_ack", 32'(Mem_Req_Ack), 32'd0);
    MemWrite = 1'b0; rst = 1'b0;
    do_read(32'h300, rd, lat);
    chk("rst_wr_not_in_ram", rd, 32'h00000000);
    chk("rst_wr_data_cnt", data_cnt, 32'd1);

    @(negedge clk);
    addr_3 = 32'h10; wd_3 = 32'h24020005; mw_3 = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      if (mack_3) begin
        seen = 1'b1;
        mw_3 = 1'b0;
      end
    end
    if (!seen) begin
      mw_3 = 1'b0;
      chk("lat3_wr_timeout", 32'd0, 32'd1);
    end
    @(negedge clk);
    pc_3 = 32'h10; iv_3 = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      if (iack_3) begin
        seen = 1'b1;
        iv_3 = 1'b0;
      end
    end
    if (!seen) begin
      iv_3 = 1'b0;
      chk("lat3_ack_timeout", 32'd0, 32'd1);
    end
    lat = 0;
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      lat++;
      seen = ivld_3;
    end
    chk("lat3_latency", 32'(lat), 32'd4);
    chk("lat3_instruction", ins_3, 32'h24020005);
    chk("lat3_inst_cnt", icnt_3, 32'd1);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
